// File: rtl/keypad_scanner.sv
// Matrix keypad scanner and debouncer for a 5-row x 4-column active-low key matrix.
// Each row is driven for SCAN_DIV cycles and the columns are sampled once at the end
// of that dwell. The first hit in scan order (lowest code) is the frame result. A new
// result must repeat for DEBOUNCE consecutive frames before it is committed. Every
// commit emits a single ready pulse. A key press, a key-to-key change and a release
// each produce one commit, and a release reports code 31.
//
// Output timing: keycode_o and pressed_o update on the EVAL->STROBE edge, and ready_o
// is registered out of STROBE. ready_o is therefore high during the first cycle of the
// following frame. This keeps keycode_o stable for one full cycle before ready_o rises.

module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] col_n_i,
  output logic [4:0] row_n_o,
  output logic [4:0] keycode_o,
  output logic       ready_o,
  output logic       pressed_o
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW   = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [4:0]        KeyNone   = 5'd31;
  localparam logic [4:0]        RowNIdle  = 5'b11111;
  localparam logic [4:0]        RowNFirst = 5'b11110;
  localparam logic [2:0]        RowLast   = 3'd4;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntTarget = CntW'(DEBOUNCE);

  typedef enum logic [1:0] {
    StScan   = 2'd0,
    StEval   = 2'd1,
    StStrobe = 2'd2
  } state_e;

  // Column synchronizer.
  logic [3:0] col_s1_q, col_s2_q;

  // Scan and debounce state.
  state_e            state_q;
  logic [2:0]        row_q;
  logic [DwellW-1:0] dwell_q;
  logic              hit_q;
  logic [4:0]        hit_code_q;
  logic [4:0]        stable_q;
  logic [4:0]        cand_q;
  logic [CntW-1:0]   cnt_q;

  // Registered outputs.
  logic [4:0] row_n_q;
  logic [4:0] keycode_q;
  logic       ready_q;
  logic       pressed_q;

  // Decode helpers.
  logic            col_hit;
  logic [1:0]      col_idx;
  logic [4:0]      row_code;
  logic [4:0]      frame_result;
  logic [CntW-1:0] cnt_inc;
  logic            is_stable;
  logic            is_cand;
  logic            commit;
  logic [2:0]      row_next;
  logic [4:0]      row_n_next;

  // Two-flop synchronizer for the asynchronous column sense lines.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_s1_q <= 4'b1111;
      col_s2_q <= 4'b1111;
    end else begin
      col_s1_q <= col_n_i;
      col_s2_q <= col_s1_q;
    end
  end

  // Lowest-numbered low column on the driven row, and its key code.
  always_comb begin
    col_hit = ~&col_s2_q;
    col_idx = 2'd3;
    if (!col_s2_q[0]) begin
      col_idx = 2'd0;
    end else if (!col_s2_q[1]) begin
      col_idx = 2'd1;
    end else if (!col_s2_q[2]) begin
      col_idx = 2'd2;
    end
    // row*4 + col
    row_code   = {row_q, col_idx};
    row_next   = row_q + 3'd1;
    row_n_next = ~(5'b00001 << row_next);
  end

  // Frame result and debounce decision, evaluated in EVAL.
  always_comb begin
    frame_result = hit_q ? hit_code_q : KeyNone;
    cnt_inc      = cnt_q + CntW'(1);
    is_stable    = (frame_result == stable_q);
    is_cand      = (frame_result == cand_q);
    commit       = 1'b0;
    if (!is_stable) begin
      if (is_cand) begin
        commit = (cnt_inc == CntTarget);
      end else begin
        commit = (DEBOUNCE == 1);
      end
    end
  end

  // Scan / evaluate / strobe sequencer with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StScan;
      row_q      <= '0;
      dwell_q    <= '0;
      hit_q      <= 1'b0;
      hit_code_q <= KeyNone;
      stable_q   <= KeyNone;
      cand_q     <= KeyNone;
      cnt_q      <= '0;
      row_n_q    <= RowNFirst;
      keycode_q  <= KeyNone;
      ready_q    <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StScan: begin
          ready_q <= 1'b0;
          if (dwell_q == DwellLast) begin
            dwell_q <= '0;
            // Only the first hit of the frame is kept, so the lowest code wins.
            if (!hit_q && col_hit) begin
              hit_q      <= 1'b1;
              hit_code_q <= row_code;
            end
            if (row_q == RowLast) begin
              state_q <= StEval;
              row_n_q <= RowNIdle;
            end else begin
              row_q   <= row_next;
              row_n_q <= row_n_next;
            end
          end else begin
            dwell_q <= dwell_q + DwellW'(1);
          end
        end

        StEval: begin
          row_q      <= '0;
          dwell_q    <= '0;
          hit_q      <= 1'b0;
          hit_code_q <= KeyNone;
          if (is_stable) begin
            cnt_q <= '0;
          end else if (is_cand) begin
            cnt_q <= cnt_inc;
          end else begin
            cand_q <= frame_result;
            cnt_q  <= CntW'(1);
          end
          if (commit) begin
            stable_q  <= frame_result;
            keycode_q <= frame_result;
            pressed_q <= (frame_result != KeyNone);
            cnt_q     <= '0;
            state_q   <= StStrobe;
            row_n_q   <= RowNIdle;
          end else begin
            state_q <= StScan;
            row_n_q <= RowNFirst;
          end
        end

        StStrobe: begin
          ready_q    <= 1'b1;
          state_q    <= StScan;
          row_q      <= '0;
          dwell_q    <= '0;
          hit_q      <= 1'b0;
          hit_code_q <= KeyNone;
          row_n_q    <= RowNFirst;
        end

        default: begin
          state_q <= StScan;
          row_q   <= '0;
          dwell_q <= '0;
          ready_q <= 1'b0;
          row_n_q <= RowNFirst;
        end
      endcase
    end
  end

  assign row_n_o   = row_n_q;
  assign keycode_o = keycode_q;
  assign ready_o   = ready_q;
  assign pressed_o = pressed_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad scanner and debouncer that drives a 5-row × 4-column active-low key matrix and produces the `keycode`/`ready` stream consumed by the piano note mapper. It reports each debounced key press, key change and release exactly once. Every `ready` strobe carries a `keycode` that is stable before the rising edge and held afterwards. It sits between the board keypad pins and the note/octave logic.

## Interface
- `SCAN_DIV`, 50000: clock cycles each row is driven (dwell); ≥ 3.
- `DEBOUNCE`, 4: consecutive identical frame results required to commit a new state; ≥ 1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `col_n`  in  4  column sense lines, active-low, asynchronous to `clk`.
- `row_n`  out  5  row drive, one-hot active-low; all-high outside SCAN.
- `keycode`  out  5  last committed code: 0–19 = key, 31 = release/no key.
- `ready`  out  1  one-cycle-high strobe; `keycode` is valid when it rises.
- `pressed`  out  1  level: a key is currently committed as held.

## Operation
- Key code = row*4 + col, with row 0–4 and col 0–3. Codes 20–30 are never produced. Code 31 = NONE.
- `col_n` passes through a 2-flop synchronizer; both flops reset to 4'b1111.
- FSM states:
  - SCAN: drives row `r`, counts dwell 0..SCAN_DIV-1. On dwell count SCAN_DIV-1 it samples synced `col_n`.
    - If no hit has been recorded yet this frame and any column is low, it records the code of the lowest-numbered low column.
    - Then `r` is incremented. After r=4 it goes to EVAL.
  - EVAL: one cycle, `row_n` all-high. Frame result = recorded code, or NONE. Debounce rules:
    - Result == stable: `cnt` <= 0.
    - Else if result == cand: `cnt` <= `cnt`+1. If `cnt`+1 == DEBOUNCE, commit.
    - Else: `cand` <= result; `cnt` <= 1. If DEBOUNCE == 1, commit.
    - Commit: stable <= result, `keycode` <= result, `cnt` <= 0, go to STROBE. Otherwise go to SCAN with r=0.
  - STROBE: one cycle, `ready`=1, `row_n` all-high. Then SCAN with r=0, and the hit record is cleared.
- Multiple keys in one frame: the first hit in scan order wins (lowest code).
- Key A → key B without an intervening empty frame: commit B directly. No NONE strobe is emitted.
- `pressed` = (stable != NONE), updated together with `keycode`.
- `cnt` width = clog2(DEBOUNCE+1). Dwell counter width = clog2(SCAN_DIV). Neither counter wraps.

## Timing
- Reset values:
  - `row_n`=5'b11110 (SCAN, r=0, dwell 0).
  - `keycode`=31, `ready`=0, `pressed`=0.
  - stable=cand=NONE, `cnt`=0, synchronizer all ones.
- Frame length = 5*SCAN_DIV+1 cycles without a commit, or 5*SCAN_DIV+2 cycles with a commit.
- `keycode` and `pressed` change on the EVAL→STROBE edge. `ready` is high for the following single cycle. `keycode` is stable for ≥1 cycle before `ready` rises and is held until the next commit.
- Latency from a stable `col_n` change to `ready`: at most (DEBOUNCE+1) frames + 2 synchronizer cycles.
- Column changes during a dwell take effect only at that row's sample point.
- `rst` asserted mid-frame or during STROBE: immediate return to reset values. `ready` drops asynchronously. No strobe is emitted for the interrupted frame.

## Test plan
- Press and release with SCAN_DIV=4, DEBOUNCE=3: hold row 2/col 1 (code 9) from reset.
  - Required: exactly one `ready` with `keycode`=9 and `pressed`=1, rising at cycle 3 frames × 21 + 1 (±2 sync).
  - Then release. Required: exactly one `ready` with `keycode`=31 and `pressed`=0 three frames later.
- Bounce: toggle the code-5 contact every frame for 6 frames, then hold it.
  - Required: no `ready` during the toggling. A single strobe with code 5 after 3 stable frames.
- Rollover and multi-key:
  - Hold code 4, then switch to code 13 with no gap. Required: strobes 4 then 13, with no 31 in between.
  - Hold codes 7 and 16 together. Required: code 7 reported.
- Row timing: check `row_n` cycles 11110, 11101, 11011, 10111, 01111 with 4 cycles each, then 11111 during EVAL/STROBE. Check that `keycode` is stable one cycle before and after every `ready` rise.
- Reset mid-debounce: after 2 stable frames of code 19, assert `rst`.
  - Required: outputs return to reset values immediately.
  - After release of `rst` with the key still held, the strobe for 19 appears only after 3 fresh frames.
- DEBOUNCE=1 corner: a single-frame press of code 0 produces a `ready` with `keycode`=0. The next empty frame produces `keycode`=31.
